// File: rtl/i2c_mon_pkg.sv
// Shared types and widths for the passive I2C bus monitor.
package i2c_mon_pkg;

   localparam int I2C_BYTE_W = 8;
   localparam int BIT_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ACK   = 2'd2
   } mon_state_t;

endpackage

// File: rtl/i2c_cond_det.sv
// Previous-sample registers for filtered SCL/SDA and START/STOP/SCL-rise decode.
// Shared with the bus-driver block, so it carries no monitor-specific state.
module i2c_cond_det (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic start,
   output logic stop,
   output logic bus_change
);

   logic scl_q;
   logic sda_q;

   // Lines idle high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_in;
         sda_q <= sda_in;
      end
   end

   assign scl_rise   = ~scl_q & scl_in;
   assign start      = scl_q & scl_in & sda_q & ~sda_in;
   assign stop       = scl_q & scl_in & ~sda_q & sda_in;
   assign bus_change = (scl_q ^ scl_in) | (sda_q ^ sda_in);

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C decoder: reports START/rSTART/STOP and each byte plus ACK as strobes.
// Optional bus-stall timeout is built when I2C_MON_TIMEOUT_EN is defined.
module i2c_bus_monitor
   import i2c_mon_pkg::*;
#(
   parameter int TIMEOUT_WIDTH = 20
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scl_in,
   input  logic                  sda_in,
   output logic                  busy,
   output logic                  start_p,
   output logic                  rstart_p,
   output logic                  stop_p,
   output logic                  byte_valid,
   output logic [I2C_BYTE_W-1:0] byte_data,
   output logic                  byte_ack,
   output logic                  byte_is_addr,
   output logic                  frame_err,
   output logic                  timeout_p
);

   logic scl_rise;
   logic start;
   logic stop;
   logic bus_change;
   logic tmo_hit;

   mon_state_t            state, state_d;
   logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
   logic [I2C_BYTE_W-1:0] shift_q, shift_d;
   logic                  first_flag, first_d;
   logic                  busy_d, start_d, rstart_d, stop_d, valid_d, ferr_d;
   logic [I2C_BYTE_W-1:0] data_d;
   logic                  ack_d, addr_d;

   i2c_cond_det u_cond_det (
      .clk        (clk),
      .rst        (rst),
      .scl_in     (scl_in),
      .sda_in     (sda_in),
      .scl_rise   (scl_rise),
      .start      (start),
      .stop       (stop),
      .bus_change (bus_change)
   );

`ifdef I2C_MON_TIMEOUT_EN
   logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

   assign tmo_hit = (state != IDLE) && !bus_change && (tmo_cnt == {TIMEOUT_WIDTH{1'b1}});

   // Any line activity or an idle bus restarts the stall count.
   always_ff @(posedge clk) begin
      if (rst || state == IDLE || bus_change || tmo_hit) begin
         tmo_cnt <= '0;
      end else if (busy) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0 & bus_change & (TIMEOUT_WIDTH > 0);
`endif

   // Next-state and next-output decode; outputs are registered below.
   always_comb begin
      state_d  = state;
      bit_cnt_d = bit_cnt;
      shift_d  = shift_q;
      first_d  = first_flag;
      busy_d   = busy;
      start_d  = 1'b0;
      rstart_d = 1'b0;
      stop_d   = 1'b0;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      data_d   = byte_data;
      ack_d    = byte_ack;
      addr_d   = byte_is_addr;

      case (state)
         IDLE: begin
            if (start) begin
               start_d   = 1'b1;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               first_d   = 1'b1;
               state_d   = SHIFT;
            end
         end
         default: begin
            if (tmo_hit) begin
               busy_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = IDLE;
            end else if (start) begin
               rstart_d  = 1'b1;
               ferr_d    = (bit_cnt != '0) || (state == ACK);
               bit_cnt_d = '0;
               first_d   = 1'b1;
               state_d   = SHIFT;
            end else if (stop) begin
               stop_d    = 1'b1;
               ferr_d    = (bit_cnt != '0) || (state == ACK);
               busy_d    = 1'b0;
               bit_cnt_d = '0;
               state_d   = IDLE;
            end else if (scl_rise) begin
               if (state == SHIFT) begin
                  shift_d   = {shift_q[I2C_BYTE_W-2:0], sda_in};
                  bit_cnt_d = bit_cnt + 1'b1;
                  if (bit_cnt == BIT_CNT_W'(I2C_BYTE_W - 1)) begin
                     state_d = ACK;
                  end
               end else begin
                  valid_d   = 1'b1;
                  data_d    = shift_q;
                  ack_d     = ~sda_in;
                  addr_d    = first_flag;
                  first_d   = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = SHIFT;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift_q      <= '0;
         first_flag   <= 1'b0;
         busy         <= 1'b0;
         start_p      <= 1'b0;
         rstart_p     <= 1'b0;
         stop_p       <= 1'b0;
         byte_valid   <= 1'b0;
         frame_err    <= 1'b0;
         timeout_p    <= 1'b0;
         byte_data    <= '0;
         byte_ack     <= 1'b0;
         byte_is_addr <= 1'b0;
      end else begin
         state        <= state_d;
         bit_cnt      <= bit_cnt_d;
         shift_q      <= shift_d;
         first_flag   <= first_d;
         busy         <= busy_d;
         start_p      <= start_d;
         rstart_p     <= rstart_d;
         stop_p       <= stop_d;
         byte_valid   <= valid_d;
         frame_err    <= ferr_d;
         timeout_p    <= tmo_hit;
         byte_data    <= data_d;
         byte_ack     <= ack_d;
         byte_is_addr <= addr_d;
      end
   end

endmodule
